// File: rtl/mpc_constraint_violation_scan.sv
// Scans the constraint residual buffer for max/argmax and, with MPC_SCAN_VIOL_COUNT_EN, counts rows above tol.
// Start-to-ap_done latency N+2 cycles, initiation interval N+3; ap_start is ignored while a scan is in flight.
module mpc_constraint_violation_scan #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 3,
  parameter int AddressRange = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ap_start,
  output logic                    ap_done,
  output logic                    ap_idle,
  output logic                    ap_ready,
  input  logic [DataWidth-1:0]    tol,
  output logic [AddressWidth-1:0] address0,
  output logic                    ce0,
  input  logic [DataWidth-1:0]    q0,
  output logic [DataWidth-1:0]    max_val,
  output logic [AddressWidth-1:0] max_idx,
  output logic [AddressWidth:0]   viol_count,
  output logic                    any_viol
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  // One extra counter bit lets N = 2^AddressWidth terminate without wrapping.
  localparam logic [AddressWidth:0] LastCnt = AddressRange[AddressWidth:0];

  state_t                  state_q, state_d;
  logic [AddressWidth:0]   cnt_q, cnt_d;
  logic [AddressWidth-1:0] address0_q, address0_d;
  logic                    ce0_q, ce0_d;
  logic                    vld_q, vld_d;
  logic [AddressWidth-1:0] idx_q, idx_d;
  logic [DataWidth-1:0]    max_val_q, max_val_d;
  logic [AddressWidth-1:0] max_idx_q, max_idx_d;
  logic                    ap_done_q, ap_done_d;
  logic                    ap_idle_q, ap_idle_d;
  logic [AddressWidth:0]   viol_count_q, viol_count_d;
  logic                    any_viol_q, any_viol_d;
`ifdef MPC_SCAN_VIOL_COUNT_EN
  logic [DataWidth-1:0]    tol_q, tol_d;
`else
  logic                    unused_tol;
  assign unused_tol = ^tol;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    address0_d   = address0_q;
    ce0_d        = 1'b0;
    vld_d        = ce0_q;
    idx_d        = address0_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    viol_count_d = viol_count_q;
`ifdef MPC_SCAN_VIOL_COUNT_EN
    tol_d        = tol_q;
`endif
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          state_d      = READ;
          ce0_d        = 1'b1;
          address0_d   = '0;
          cnt_d        = {{AddressWidth{1'b0}}, 1'b1};
          viol_count_d = '0;
`ifdef MPC_SCAN_VIOL_COUNT_EN
          tol_d        = tol;
`endif
        end
      end
      READ: begin
        if (cnt_q == LastCnt) begin
          state_d = DRAIN;
        end else begin
          ce0_d      = 1'b1;
          address0_d = cnt_q[AddressWidth-1:0];
          cnt_d      = cnt_q + 1'b1;
        end
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Row 0 seeds the maximum; later rows need a strict win so ties keep the lowest index.
    if (vld_q) begin
      if (idx_q == '0 || $signed(q0) > $signed(max_val_q)) begin
        max_val_d = q0;
        max_idx_d = idx_q;
      end
`ifdef MPC_SCAN_VIOL_COUNT_EN
      if ($signed(q0) > $signed(tol_q)) begin
        viol_count_d = viol_count_q + 1'b1;
      end
`endif
    end

`ifdef MPC_SCAN_VIOL_COUNT_EN
    any_viol_d = (viol_count_d != '0);
`else
    viol_count_d = '0;
    any_viol_d   = 1'b0;
`endif
    ap_done_d = (state_d == DONE);
    ap_idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      address0_q   <= '0;
      ce0_q        <= 1'b0;
      vld_q        <= 1'b0;
      idx_q        <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      ap_done_q    <= 1'b0;
      ap_idle_q    <= 1'b1;
      viol_count_q <= '0;
      any_viol_q   <= 1'b0;
`ifdef MPC_SCAN_VIOL_COUNT_EN
      tol_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      address0_q   <= address0_d;
      ce0_q        <= ce0_d;
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      ap_done_q    <= ap_done_d;
      ap_idle_q    <= ap_idle_d;
      viol_count_q <= viol_count_d;
      any_viol_q   <= any_viol_d;
`ifdef MPC_SCAN_VIOL_COUNT_EN
      tol_q        <= tol_d;
`endif
    end
  end

  assign ap_done    = ap_done_q;
  assign ap_ready   = ap_done_q;
  assign ap_idle    = ap_idle_q;
  assign address0   = address0_q;
  assign ce0        = ce0_q;
  assign max_val    = max_val_q;
  assign max_idx    = max_idx_q;
  assign viol_count = viol_count_q;
  assign any_viol   = any_viol_q;

endmodule

// File: tb/tb_mpc_constraint_violation_scan.sv
// Bench for mpc_constraint_violation_scan: cycle-count reference model plus directed scenarios.
module tb_mpc_constraint_violation_scan;
  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_done, ap_idle, ap_ready, ce0, any_viol;
  logic [31:0] tol = '0;
  logic [2:0]  address0, max_idx;
  logic [31:0] q0 = '0;
  logic [31:0] max_val;
  logic [3:0]  viol_count;

  logic [31:0] mem [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mpc_constraint_violation_scan #(.DataWidth(32), .AddressWidth(3), .AddressRange(N)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .tol(tol), .address0(address0), .ce0(ce0), .q0(q0),
    .max_val(max_val), .max_idx(max_idx), .viol_count(viol_count), .any_viol(any_viol)
  );

  // Single-port buffer: data appears one cycle after the enabled read.
  always @(posedge clk) if (ce0) q0 <= mem[address0];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: t = cycles since the accepted start (-1 while idle).
  int          t = -1;
  logic [31:0] pend_max, exp_max = '0;
  logic [2:0]  pend_idx, exp_idx = '0;
  logic [3:0]  pend_viol, exp_viol = '0;

  task automatic scan_result(input logic [31:0] tl, output logic [31:0] mx,
                             output logic [2:0] ix, output logic [3:0] vc);
    mx = mem[0]; ix = 0; vc = 0;
    for (int i = 0; i < N; i++) begin
      if ($signed(mem[i]) > $signed(mx)) begin mx = mem[i]; ix = 3'(i); end
`ifdef MPC_SCAN_VIOL_COUNT_EN
      if ($signed(mem[i]) > $signed(tl)) vc++;
`endif
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t = -1; exp_max = '0; exp_idx = '0; exp_viol = '0;
    end else if (t == -1) begin
      if (ap_start) begin
        t = 1;
        scan_result(tol, pend_max, pend_idx, pend_viol);
      end
    end else if (t == N + 2) begin
      t = -1;
    end else begin
      t++;
      if (t == N + 2) begin exp_max = pend_max; exp_idx = pend_idx; exp_viol = pend_viol; end
    end
  end

  always @(negedge clk) begin
    chk("ap_idle", ap_idle, t == -1);
    chk("ap_done", ap_done, t == N + 2);
    chk("ap_ready", ap_ready, t == N + 2);
    chk("ce0", ce0, t >= 1 && t <= N);
    if (t >= 1 && t <= N) chk("address0", address0, 64'(t - 1));
    if (reset) chk("address0_rst", address0, 0);
    if (t == -1 || t == N + 2) begin
      chk("max_val", max_val, exp_max);
      chk("max_idx", max_idx, exp_idx);
      chk("viol_count", viol_count, exp_viol);
      chk("any_viol", any_viol, exp_viol != 0);
    end
  end

  // Pulses start, optionally pokes ap_start/tol mid-scan, returns cycles to ap_done.
  task automatic run_scan(input bit noisy, output int lat);
    @(posedge clk); #1 ap_start = 1'b1;
    lat = 0;
    @(posedge clk); #1 ap_start = 1'b0; lat = 1;
    if (noisy) tol = $urandom;
    while (!ap_done && lat < 40) begin
      @(posedge clk); #1 lat++;
      ap_start = (noisy && lat <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    ap_start = 1'b0;
    if (!ap_done) chk("done_timeout", lat, N + 2);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 6)) - 32'd3;
      default: return $urandom;
    endcase
  endfunction

  int lat;
  int ndone;
  int done_at [3];
  int ce_cnt;
  logic [31:0] vals1 [N] = '{32'd3, -32'd1, 32'd7, 32'd2, 32'd7, 32'd0, -32'd5, 32'd1};

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    #12;
    chk("rst_idle", ap_idle, 1);
    chk("rst_ce0", ce0, 0);
    chk("rst_max", max_val, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Scenario 1: mixed residuals, tol = 2.
    for (int i = 0; i < N; i++) mem[i] = vals1[i];
    tol = 32'd2;
    run_scan(1'b0, lat);
    chk("s1_latency", lat, 10);
    chk("s1_max", max_val, 32'd7);
    chk("s1_idx", max_idx, 2);
`ifdef MPC_SCAN_VIOL_COUNT_EN
    chk("s1_viol", viol_count, 3);
    chk("s1_any", any_viol, 1);
`else
    chk("s1_viol", viol_count, 0);
    chk("s1_any", any_viol, 0);
`endif

    // Scenario 2: all -100, tol = 0; count enabled reads.
    for (int i = 0; i < N; i++) mem[i] = -32'd100;
    tol = '0;
    @(posedge clk); #1 ap_start = 1'b1;
    ce_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1 ap_start = 1'b0;
      if (ce0) begin chk("s2_addr_seq", address0, 64'(ce_cnt)); ce_cnt++; end
    end
    chk("s2_ce0_cycles", ce_cnt, 8);
    chk("s2_max", max_val, 32'hFFFF_FF9C);
    chk("s2_idx", max_idx, 0);
    chk("s2_viol", viol_count, 0);
    chk("s2_any", any_viol, 0);

    // Scenario 3: extreme values, tol most negative.
    for (int i = 0; i < N; i++) mem[i] = '0;
    mem[N-1] = 32'h7FFF_FFFF;
    tol = 32'h8000_0000;
    run_scan(1'b0, lat);
    chk("s3_max", max_val, 32'h7FFF_FFFF);
    chk("s3_idx", max_idx, 7);
`ifdef MPC_SCAN_VIOL_COUNT_EN
    chk("s3_viol", viol_count, 8);
`else
    chk("s3_viol", viol_count, 0);
`endif

    // Scenario 4: ap_start held high for 30 cycles.
    for (int i = 0; i < N; i++) mem[i] = vals1[i];
    tol = 32'd2;
    @(posedge clk); #1 ap_start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 30) ap_start = 1'b0;
      if (ap_done) begin
        if (ndone < 3) done_at[ndone] = k;
        ndone++;
      end
    end
    chk("s4_ndone", ndone, 3);
    chk("s4_done0", done_at[0], 10);
    chk("s4_done1", done_at[1], 21);
    chk("s4_done2", done_at[2], 32);

    // Scenario 5: asynchronous reset at cycle 5 of a scan.
    mem[0] = 32'd50;
    @(posedge clk); #1 ap_start = 1'b1;
    @(posedge clk); #1 ap_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("s5_ce0", ce0, 0);
    chk("s5_idle", ap_idle, 1);
    chk("s5_done", ap_done, 0);
    chk("s5_addr", address0, 0);
    chk("s5_max", max_val, 0);
    chk("s5_idx", max_idx, 0);
    chk("s5_viol", viol_count, 0);
    chk("s5_any", any_viol, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_scan(1'b0, lat);
    chk("s5_restart_latency", lat, 10);
    chk("s5_restart_max", max_val, 32'd50);
    chk("s5_restart_idx", max_idx, 0);

    // Randomized scans with mid-scan start and tol noise.
    for (int s = 0; s < 60; s++) begin
      for (int i = 0; i < N; i++) mem[i] = rand_val();
      tol = rand_val();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_scan(1'b1, lat);
      chk("rnd_latency", lat, 10);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
